// File: rtl/float_cvt_hw_int_if.sv
// float_cvt_hw_int_if: operand/result handshake bundle for the float16 to int32 converter
interface float_cvt_hw_int_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] float16;
    logic [2:0]  rounding_mode;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int32;
    logic        flag_nv;
    logic        flag_nx;
    modport master (
        output in_valid, float16, rounding_mode, is_unsigned, out_ready,
        input  in_ready, out_valid, int32, flag_nv, flag_nx
    );
    modport slave (
        input  in_valid, float16, rounding_mode, is_unsigned, out_ready,
        output in_ready, out_valid, int32, flag_nv, flag_nx
    );
endinterface

// File: rtl/float_cvt_hw_int.sv
// float_cvt_hw_int: 3-stage binary16 to int32/uint32 converter with RISC-V rounding and NV/NX flags
module float_cvt_hw_int #(
    parameter int PIPE_STAGES = 3
) (
    input logic clk,
    input logic rst,
    float_cvt_hw_int_if.slave bus
);
    typedef enum logic [2:0] {C_ZERO, C_SUB, C_NORM, C_INF, C_NAN} cls_t;

    logic [PIPE_STAGES-1:0] vld;
    logic [PIPE_STAGES-1:0] en;

    logic [4:0]  exp5;
    logic [9:0]  frac;
    cls_t        cls;

    logic        s1_sign;
    cls_t        s1_cls;
    logic [10:0] s1_sig;
    logic [5:0]  s1_exp;
    logic [2:0]  s1_rm;
    logic        s1_uns;

    logic [25:0] q;
    logic        neg_e;
    logic [15:0] mag;
    logic        g;
    logic        s;
    logic        rup;

    logic        s2_sign;
    cls_t        s2_cls;
    logic [16:0] s2_mag;
    logic        s2_nx;
    logic [2:0]  s2_rm;
    logic        s2_uns;

    logic [31:0] mag32;
    logic [31:0] sres;
    logic        rsv;
    logic        nan;
    logic        inf;
    logic        special;
    logic [31:0] res;

    // a stage loads when it is empty or its successor moves on this cycle
    always_comb begin
        en[2] = !vld[2] || bus.out_ready;
        en[1] = !vld[1] || en[2];
        en[0] = !vld[0] || en[1];
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = vld[2];

    // stage occupancy; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else begin
            if (en[0]) vld[0] <= bus.in_valid;
            if (en[1]) vld[1] <= vld[0];
            if (en[2]) vld[2] <= vld[1];
        end
    end

    // decode: classify operand and build significand with hidden bit
    always_comb begin
        exp5 = bus.float16[14:10];
        frac = bus.float16[9:0];
        cls  = (exp5 == 5'd0)  ? ((frac == 10'd0) ? C_ZERO : C_SUB) :
               (exp5 == 5'd31) ? ((frac == 10'd0) ? C_INF  : C_NAN) : C_NORM;
    end

    // S1 registers
    always_ff @(posedge clk) begin
        if (en[0]) begin
            s1_sign <= bus.float16[15];
            s1_cls  <= cls;
            s1_sig  <= {exp5 != 5'd0, frac};
            s1_exp  <= {1'b0, exp5} - 6'd15;
            s1_rm   <= bus.rounding_mode;
            s1_uns  <= bus.is_unsigned;
        end
    end

    // align: q holds the value with 10 fraction bits, so integer/guard/sticky fall out of fixed slices
    always_comb begin
        q     = 26'(s1_sig) << s1_exp[3:0];
        neg_e = s1_exp[5] || (s1_cls == C_SUB);
        mag   = neg_e ? 16'd0 : q[25:10];
        g     = neg_e ? (s1_exp == 6'h3F) : q[9];
        s     = neg_e ? ((s1_exp == 6'h3F) ? |s1_sig[9:0] : |s1_sig) : |q[8:0];
        rup   = (s1_rm == 3'd0) ? (g && (s || mag[0])) :
                (s1_rm == 3'd2) ? (s1_sign && (g || s)) :
                (s1_rm == 3'd3) ? (!s1_sign && (g || s)) :
                (s1_rm == 3'd4) ? g : 1'b0;
    end

    // S2 registers: rounded magnitude and inexact
    always_ff @(posedge clk) begin
        if (en[1]) begin
            s2_sign <= s1_sign;
            s2_cls  <= s1_cls;
            s2_mag  <= 17'(mag) + 17'(rup);
            s2_nx   <= g || s;
            s2_rm   <= s1_rm;
            s2_uns  <= s1_uns;
        end
    end

    // result: sign application, saturation of specials and flag selection
    always_comb begin
        mag32   = 32'(s2_mag);
        sres    = s2_sign ? -mag32 : mag32;
        rsv     = s2_rm > 3'd4;
        nan     = s2_cls == C_NAN;
        inf     = s2_cls == C_INF;
        special = rsv || nan || inf || (s2_uns && s2_sign && s2_mag != 17'd0);
        res     = rsv ? 32'd0 :
                  (nan || (inf && !s2_sign)) ? (s2_uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF) :
                  inf ? (s2_uns ? 32'd0 : 32'h8000_0000) :
                  (s2_uns && s2_sign) ? 32'd0 : sres;
    end

    // S3 output registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.int32   <= '0;
            bus.flag_nv <= 1'b0;
            bus.flag_nx <= 1'b0;
        end else if (en[2]) begin
            bus.int32   <= res;
            bus.flag_nv <= special;
            bus.flag_nx <= !special && s2_nx;
        end
    end
endmodule

// File: tb/tb_float_cvt_hw_int.sv
// tb_float_cvt_hw_int: vector table plus scoreboard checks for the float16 converter
module tb_float_cvt_hw_int;
    typedef struct packed {
        logic [31:0] val;
        logic        nv;
        logic        nx;
    } res_t;

    typedef struct {
        logic [15:0] f;
        logic [2:0]  rm;
        logic        uns;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    vec_t vecs[$];
    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_out = 0;
    int   stale = 0;
    int   gaps = 0;
    logic track_gaps = 1'b0;
    logic hold_v = 1'b0;
    res_t held;
    logic run_done;

    always #5 clk = ~clk;

    float_cvt_hw_int_if bus();

    float_cvt_hw_int #(.PIPE_STAGES(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic add(input logic [15:0] f, input logic [2:0] rm, input logic uns,
                       input logic [31:0] val, input logic nv, input logic nx);
        vec_t v;
        v.f = f;
        v.rm = rm;
        v.uns = uns;
        v.exp = '{val, nv, nx};
        vecs.push_back(v);
    endtask

    task automatic send(input vec_t v);
        int c = 0;
        bus.in_valid      = 1'b1;
        bus.float16       = v.f;
        bus.rounding_mode = v.rm;
        bus.is_unsigned   = v.uns;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            c++;
            if (c > 100) begin
                errors++;
                checks++;
                $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", c);
                bus.in_valid = 1'b0;
                return;
            end
        end
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (sb.size() > 0 && c < 200) begin
            @(posedge clk);
            c++;
        end
        #1;
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    // scoreboard monitor: compare transfers, check output stability while stalled
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        if (track_gaps && sb.size() > 0 && !bus.out_valid) gaps++;
        if (!rst && bus.out_valid) begin
            cur = '{bus.int32, bus.flag_nv, bus.flag_nx};
            if (!bus.out_ready) begin
                if (hold_v) chk("stall_hold", 64'(cur), 64'(held));
                held = cur;
                hold_v = 1'b1;
            end else begin
                hold_v = 1'b0;
                if (sb.size() == 0) begin
                    stale++;
                    errors++;
                    checks++;
                    $display("FAIL unexpected_output: got %h expected no result", cur);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("result_%0d", n_out), 64'(cur), 64'(e));
                    n_out++;
                end
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        int low_cnt;
        add(16'h3E00, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
        add(16'h3E00, 3'd1, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        add(16'h4100, 3'd0, 1'b0, 32'h0000_0002, 1'b0, 1'b1);
        add(16'h4100, 3'd4, 1'b0, 32'h0000_0003, 1'b0, 1'b1);
        add(16'hBE00, 3'd2, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        add(16'hBE00, 3'd3, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        add(16'hC500, 3'd0, 1'b0, 32'hFFFF_FFFB, 1'b0, 1'b0);
        add(16'h7BFF, 3'd0, 1'b1, 32'h0000_FFE0, 1'b0, 1'b0);
        add(16'h8000, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
        add(16'h0001, 3'd3, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        add(16'h7C00, 3'd0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        add(16'hFC00, 3'd0, 1'b0, 32'h8000_0000, 1'b1, 1'b0);
        add(16'h7E00, 3'd0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        add(16'hBA00, 3'd1, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        add(16'hBA00, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add(16'h3C00, 3'd6, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        add(16'hFC00, 3'd0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add(16'hFBFF, 3'd0, 1'b0, 32'hFFFF_0020, 1'b0, 1'b0);
        add(16'h3800, 3'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
        add(16'h3800, 3'd4, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        add(16'h0001, 3'd0, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        add(16'h4900, 3'd0, 1'b1, 32'h0000_000A, 1'b0, 1'b0);
        add(16'h3A00, 3'd0, 1'b0, 32'h0000_0001, 1'b0, 1'b1);
        add(16'h7D00, 3'd1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        add(16'h3555, 3'd3, 1'b1, 32'h0000_0001, 1'b0, 1'b1);

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.float16 = '0;
        bus.rounding_mode = '0;
        bus.is_unsigned = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_int32", 64'(bus.int32), 64'd0);
        chk("reset_nv", 64'(bus.flag_nv), 64'd0);
        chk("reset_nx", 64'(bus.flag_nx), 64'd0);
        rst = 1'b0;
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);

        // table vectors, back to back
        for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
        drain("table_drain");

        // latency of a single operand
        send(vecs[6]);
        chk("lat_e1", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_e2", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_e3", 64'(bus.out_valid), 64'd1);
        drain("lat_drain");

        // backpressure: out_ready low for cycles 4-9 of an 8-operand stream
        low_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i]);
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    bus.out_ready = !(c >= 4 && c <= 9);
                    track_gaps = (c >= 10);
                    @(negedge clk);
                    if (c >= 4 && c <= 9 && !bus.in_ready) low_cnt++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain("bp_drain");
        track_gaps = 1'b0;
        chk("bp_in_ready_low_cycles", 64'(low_cnt), 64'd6);
        chk("bp_gaps_after_release", 64'(gaps), 64'd0);

        // random backpressure over the whole table
        run_done = 1'b0;
        fork
            begin
                for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
                run_done = 1'b1;
            end
            begin
                while (!run_done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        bus.out_ready = 1'b1;
        drain("rand_drain");

        // reset with three operands in flight
        for (int i = 0; i < 3; i++) send(vecs[i]);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_int32", 64'(bus.int32), 64'd0);
        chk("midrst_nv", 64'(bus.flag_nv), 64'd0);
        chk("midrst_nx", 64'(bus.flag_nx), 64'd0);
        rst = 1'b0;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_stale", 64'(stale), 64'd0);

        send(vecs[10]);
        drain("post_reset_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/float_cvt_hw_int.md
Name: float_cvt_hw_int

Overview:
- Pipelined float16 (IEEE binary16) to int32/uint32 converter; the inverse of the FPU's int32 to float16 path.
- Sits in the FPU convert unit behind the issue stage; results and flags return to writeback.
- Uses valid/ready handshakes on input and output and a fixed 3-stage pipeline with full backpressure.
- Implements all RISC-V rounding modes and the NV/NX exception flags.

Parameters:
- PIPE_STAGES, 3, fixed pipeline depth; only the value 3 is supported.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  converter can accept an operand this cycle.
- float16  input  16  binary16 operand {sign, exp[4:0], frac[9:0]}.
- rounding_mode  input  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 reserved.
- is_unsigned  input  1  1 converts to uint32, 0 converts to int32.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- int32  output  32  converted result.
- flag_nv  output  1  invalid operation.
- flag_nx  output  1  inexact.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0, int32=0, flag_nv=0, flag_nx=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: reset drops all in-flight operands and no result is emitted for them. Reset takes priority over any handshake in the same cycle.
- Handshakes:
  - Input transfer occurs when in_valid&&in_ready.
  - Output transfer occurs when out_valid&&out_ready.
  - Stage k advances when stage k+1 is empty or stage k+1 advances in the same cycle.
  - The output stage advances on out_ready or when empty.
  - in_ready = !s1_valid || s1_advances. in_ready has no combinational path from in_valid.
  - Bubbles collapse, so 3 back-to-back operands with out_ready=1 produce 3 consecutive results.
- Latency: an operand accepted at cycle N appears with out_valid=1 at cycle N+3 if no stall. Throughput is 1 per cycle.
- int32 and flags are held stable while out_valid && !out_ready.
- S1, decode:
  - Classify the operand as zero, subnormal, normal, inf or NaN.
  - Form an 11-bit significand with the hidden bit set for normals.
  - Unbiased exponent E = exp-15.
  - Register sign, class, significand, E, rounding_mode and is_unsigned.
- S2, align:
  - If E>=10: magnitude = sig<<(E-10), at most 16 bits; guard=sticky=0.
  - If 0<=E<10: magnitude = sig>>(10-E); guard is the bit just below the LSB; sticky is the OR of the remaining shifted-out bits.
  - If E<0, or the operand is subnormal: magnitude=0. guard=1 only when E==-1; sticky is the OR of everything else.
  - Compute round-up:
    - RNE: g&&(s||lsb).
    - RTZ: 0.
    - RDN: sign&&(g||s).
    - RUP: !sign&&(g||s).
    - RMM: g.
  - Register magnitude+roundup (17 bits), inexact=g||s.
- S3, result:
  - Signed results: apply two's complement if sign=1.
  - Signed special cases:
    - NaN or +inf: result 0x7FFFFFFF, NV=1.
    - -inf: result 0x80000000, NV=1.
  - Unsigned special cases:
    - NaN or +inf: result 0xFFFFFFFF, NV=1.
    - -inf: result 0, NV=1.
    - Negative with rounded magnitude != 0: result 0, NV=1, NX=0.
    - Negative with rounded magnitude == 0: result 0, NX=inexact.
  - Finite in-range values: NV=0, NX=inexact. Finite binary16 never overflows 32 bits (maximum 65504).
  - NX is never set together with NV.
  - Zero operands: result 0, no flags; the result is 0 for both +0 and -0.
  - Reserved rounding_mode 5-7: result 0, NV=1, NX=0.

Test Plan:
- 0x3E00 (1.5): RNE gives 0x00000002, NX=1. RTZ gives 0x00000001, NX=1.
- 0x4100 (2.5): RNE gives 2 and RMM gives 3, both with NX=1. 0xBE00 (-1.5): RDN gives 0xFFFFFFFE and RUP gives 0xFFFFFFFF, both with NX=1.
- 0xC500 (-5.0), signed, RNE: 0xFFFFFFFB with no flags. 0x7BFF, unsigned: 0x0000FFE0 with no flags. 0x8000 (-0): 0 with no flags. 0x0001 RUP: 1 with NX=1.
- Specials:
  - 0x7C00 signed: 0x7FFFFFFF, NV=1.
  - 0xFC00 signed: 0x80000000, NV=1.
  - 0x7E00 unsigned: 0xFFFFFFFF, NV=1.
  - 0xBA00 (-0.75) unsigned: RTZ gives 0 with NX=1; RNE gives 0 with NV=1.
  - rounding_mode=6: 0 with NV=1.
- Backpressure: stream 8 operands with in_valid=1 and out_ready=0 for cycles 4-9.
  - in_ready drops once the 3 stages are full.
  - Results arrive in order with none lost or duplicated, and int32 is stable while stalled.
  - Throughput returns to 1 per cycle after release.
- Reset: assert rst with 3 operands in flight. Next cycle out_valid=0 and all outputs 0; no stale results appear afterwards.
